// File: rtl/apb_kmi_fifo_slave.sv
// APB slave that buffers KMI receive and transmit bytes in independent FIFOs.
// Exposes DATA, STATUS, CONTROL and IRQ_CLR registers and runs both 4-phase handshakes.
module apb_kmi_fifo_slave #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4,
  parameter int ADDR_W   = 4
) (
  input  logic              pclk,
  input  logic              npreset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              receive,
  output logic              rx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              transmit,
  input  logic              tx_done,
  output logic              rx_interrupt,
  output logic              tx_interrupt
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_WAIT} tx_state_t;

  rx_state_t r_rxState;
  tx_state_t r_txState;

  logic [DATA_W-1:0] r_rxMem [RX_DEPTH];
  logic [DATA_W-1:0] r_txMem [TX_DEPTH];
  logic [RX_AW:0]    r_rxWr, r_rxRd;
  logic [TX_AW:0]    r_txWr, r_txRd;
  logic [2:0]        r_ctrl;
  logic              r_rxOvf;
  logic              r_done;
  logic              r_rxDone;
  logic              r_transmit;
  logic [DATA_W-1:0] r_txData;
  logic              r_rxIrq;
  logic              r_txIrq;

  logic              w_rxEmpty, w_rxFull, w_rxNotEmpty;
  logic              w_txEmpty, w_txFull, w_txBusy;
  logic              w_access, w_first, w_addrOk;
  logic              w_rxPop, w_rxPush, w_rxStart, w_rxOvfSet;
  logic              w_txPush, w_txPop;
  logic              w_ctrlWr, w_ovfClr;
  logic [5:0]        w_status;
  logic [DATA_W-1:0] w_rdData;
  logic              w_err;

  assign w_rxEmpty    = (r_rxWr == r_rxRd);
  assign w_rxFull     = (r_rxWr[RX_AW] != r_rxRd[RX_AW]) &&
                        (r_rxWr[RX_AW-1:0] == r_rxRd[RX_AW-1:0]);
  assign w_rxNotEmpty = ~w_rxEmpty;
  assign w_txEmpty    = (r_txWr == r_txRd);
  assign w_txFull     = (r_txWr[TX_AW] != r_txRd[TX_AW]) &&
                        (r_txWr[TX_AW-1:0] == r_txRd[TX_AW-1:0]);
  assign w_txBusy     = (r_txState != TX_IDLE);

  assign w_status = {w_txBusy, r_rxOvf, w_txFull, w_txEmpty, w_rxFull, w_rxNotEmpty};

  // Side effects fire only on the first access cycle of a transfer, however long psel is held.
  assign w_access = psel & penable;
  assign w_first  = w_access & ~r_done;
  assign w_addrOk = ((paddr >> 2) == '0);

  assign w_rxPop  = w_first & ~pwrite & w_addrOk & (paddr[1:0] == 2'd0) & w_rxNotEmpty;
  assign w_txPush = w_first & pwrite & w_addrOk & (paddr[1:0] == 2'd0) & ~w_txFull;
  assign w_ctrlWr = w_first & pwrite & w_addrOk & (paddr[1:0] == 2'd2);
  assign w_ovfClr = w_first & pwrite & w_addrOk & (paddr[1:0] == 2'd3) & pwdata[4];

  // A full RX FIFO still accepts a byte when the head is popped in the same cycle.
  assign w_rxStart  = (r_rxState == RX_IDLE) & receive & r_ctrl[2];
  assign w_rxPush   = w_rxStart & (~w_rxFull | w_rxPop);
  assign w_rxOvfSet = w_rxStart & w_rxFull & ~w_rxPop;
  assign w_txPop    = (r_txState == TX_BUSY) & tx_done;

  always_comb begin
    w_rdData = '0;
    w_err    = 1'b0;
    if (w_access) begin
      if (!w_addrOk) begin
        w_err = 1'b1;
      end else if (!pwrite) begin
        case (paddr[1:0])
          2'd0: begin
            if (w_rxNotEmpty) w_rdData = r_rxMem[r_rxRd[RX_AW-1:0]];
            else              w_err    = 1'b1;
          end
          2'd1:    w_rdData = DATA_W'(w_status);
          2'd2:    w_rdData = DATA_W'(r_ctrl);
          default: w_rdData = '0;
        endcase
      end else begin
        case (paddr[1:0])
          2'd0:    w_err = w_txFull;
          2'd1:    w_err = 1'b1;
          default: w_err = 1'b0;
        endcase
      end
    end
  end

  assign prdata  = (w_access && !pwrite) ? w_rdData : '0;
  assign pslverr = w_err;
  assign pready  = w_access;

  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset)      r_done <= 1'b0;
    else if (!psel)    r_done <= 1'b0;
    else if (w_access) r_done <= 1'b1;
  end

  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      r_ctrl  <= 3'b100;
      r_rxOvf <= 1'b0;
    end else begin
      if (w_ctrlWr)        r_ctrl  <= pwdata[2:0];
      if (w_rxOvfSet)      r_rxOvf <= 1'b1;
      else if (w_ovfClr)   r_rxOvf <= 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_rxPush) r_rxMem[r_rxWr[RX_AW-1:0]] <= rx_data;
    if (w_txPush) r_txMem[r_txWr[TX_AW-1:0]] <= pwdata;
  end

  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
      r_txWr <= '0;
      r_txRd <= '0;
    end else begin
      if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
    end
  end

  // RX handshake: the byte is taken (or dropped on overflow) as the request is accepted.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      r_rxState <= RX_IDLE;
      r_rxDone  <= 1'b0;
    end else begin
      case (r_rxState)
        RX_IDLE: begin
          if (w_rxStart) begin
            r_rxState <= RX_ACK;
            r_rxDone  <= 1'b1;
          end
        end
        RX_ACK: begin
          if (!receive) begin
            r_rxState <= RX_IDLE;
            r_rxDone  <= 1'b0;
          end
        end
        default: begin
          r_rxState <= RX_IDLE;
          r_rxDone  <= 1'b0;
        end
      endcase
    end
  end

  // TX handshake: the head stays in the FIFO until tx_done confirms it went out.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      r_txState  <= TX_IDLE;
      r_transmit <= 1'b0;
      r_txData   <= '0;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          if (r_ctrl[2] && !w_txEmpty) begin
            r_txData   <= r_txMem[r_txRd[TX_AW-1:0]];
            r_transmit <= 1'b1;
            r_txState  <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done) begin
            r_transmit <= 1'b0;
            r_txState  <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!tx_done) r_txState <= TX_IDLE;
        end
        default: begin
          r_txState  <= TX_IDLE;
          r_transmit <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      r_rxIrq <= 1'b0;
      r_txIrq <= 1'b0;
    end else begin
      r_rxIrq <= r_ctrl[0] & (w_rxNotEmpty | r_rxOvf);
      r_txIrq <= r_ctrl[1] & w_txEmpty & ~w_txBusy;
    end
  end

  assign rx_done      = r_rxDone;
  assign transmit     = r_transmit;
  assign tx_data      = r_txData;
  assign rx_interrupt = r_rxIrq;
  assign tx_interrupt = r_txIrq;

endmodule

// File: tb/tb_apb_kmi_fifo_slave.sv
// Directed self-checking bench for apb_kmi_fifo_slave: register map, both handshakes,
// FIFO boundaries, held transfers, interrupts and asynchronous reset.
module tb_apb_kmi_fifo_slave;

  logic       pclk = 1'b0;
  logic       npreset = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [7:0] rx_data = '0;
  logic       receive = 1'b0;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       transmit;
  logic       tx_done = 1'b0;
  logic       rx_interrupt, tx_interrupt;

  int checks = 0;
  int failures = 0;
  logic [7:0] rdVal;
  logic       rdErr;

  apb_kmi_fifo_slave #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(4), .ADDR_W(4)) dut (
    .pclk(pclk), .npreset(npreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rx_data(rx_data), .receive(receive), .rx_done(rx_done), .tx_data(tx_data),
    .transmit(transmit), .tx_done(tx_done), .rx_interrupt(rx_interrupt),
    .tx_interrupt(tx_interrupt)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apbRead(input logic [3:0] addr, output logic [7:0] data, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    checkOutput("pready_rd", pready, 1'b1);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apbWrite(input logic [3:0] addr, input logic [7:0] data, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic waitRxDone(input logic val, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (rx_done === val) break;
      @(negedge pclk);
    end
    checkOutput(tag, rx_done, val);
  endtask

  task automatic waitTransmit(input logic val, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (transmit === val) break;
      @(negedge pclk);
    end
    checkOutput(tag, transmit, val);
  endtask

  // Inject one byte through the 4-phase receive handshake.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge pclk);
    rx_data = b; receive = 1'b1;
    @(negedge pclk);
    waitRxDone(1'b1, "rx_done_rise");
    receive = 1'b0;
    @(negedge pclk);
    waitRxDone(1'b0, "rx_done_fall");
  endtask

  task automatic txHandshake();
    @(negedge pclk);
    tx_done = 1'b1;
    @(negedge pclk);
    waitTransmit(1'b0, "transmit_drop");
    tx_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge pclk);
    #1;
    checkOutput("rst_transmit", transmit, 1'b0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_rx_done", rx_done, 1'b0);
    checkOutput("rst_irqs", {rx_interrupt, tx_interrupt}, 2'b00);
    @(negedge pclk);
    npreset = 1'b1;
    #1;
    checkOutput("idle_prdata", prdata, 8'h00);
    checkOutput("idle_pslverr", pslverr, 1'b0);
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("status_rst", rdVal, 8'h04);
    checkOutput("status_rst_err", rdErr, 1'b0);
    apbRead(4'd2, rdVal, rdErr);
    checkOutput("ctrl_rst", rdVal, 8'h04);

    // Single RX byte with exact rx_done latency
    @(negedge pclk);
    rx_data = 8'h6C; receive = 1'b1;
    @(negedge pclk);
    checkOutput("rx_done_lat", rx_done, 1'b1);
    receive = 1'b0;
    @(negedge pclk);
    checkOutput("rx_done_low", rx_done, 1'b0);
    apbRead(4'd0, rdVal, rdErr);
    checkOutput("rx_rd_data", rdVal, 8'h6C);
    checkOutput("rx_rd_err", rdErr, 1'b0);
    apbRead(4'd0, rdVal, rdErr);
    checkOutput("rx_empty_data", rdVal, 8'h00);
    checkOutput("rx_empty_err", rdErr, 1'b1);

    // Two TX bytes through the transmit handshake
    apbWrite(4'd0, 8'h6C, rdErr);
    checkOutput("tx_wr1_err", rdErr, 1'b0);
    apbWrite(4'd0, 8'h05, rdErr);
    checkOutput("tx_wr2_err", rdErr, 1'b0);
    waitTransmit(1'b1, "tx1_start");
    checkOutput("tx1_data", tx_data, 8'h6C);
    txHandshake();
    waitTransmit(1'b1, "tx2_start");
    checkOutput("tx2_data", tx_data, 8'h05);
    txHandshake();
    repeat (3) @(negedge pclk);
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("tx_done_status", rdVal, 8'h04);

    // TX interrupt when idle and empty
    apbWrite(4'd2, 8'h06, rdErr);
    @(negedge pclk);
    checkOutput("tx_irq", tx_interrupt, 1'b1);
    apbWrite(4'd2, 8'h04, rdErr);
    @(negedge pclk);
    checkOutput("tx_irq_off", tx_interrupt, 1'b0);

    // RX overflow with five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("ovf_status", rdVal, 8'h17);
    for (int i = 1; i <= 4; i++) begin
      apbRead(4'd0, rdVal, rdErr);
      checkOutput("ovf_rd_data", rdVal, 32'(i));
    end
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("ovf_sticky", rdVal, 8'h14);
    apbWrite(4'd3, 8'h10, rdErr);
    checkOutput("irqclr_err", rdErr, 1'b0);
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("ovf_cleared", rdVal, 8'h04);

    // Illegal accesses
    apbRead(4'd4, rdVal, rdErr);
    checkOutput("bad_addr_rd", {rdErr, rdVal}, 9'h100);
    apbWrite(4'd1, 8'hFF, rdErr);
    checkOutput("status_wr_err", rdErr, 1'b1);
    apbWrite(4'd6, 8'h00, rdErr);
    checkOutput("bad_addr_wr_err", rdErr, 1'b1);
    apbRead(4'd2, rdVal, rdErr);
    checkOutput("ctrl_untouched", rdVal, 8'h04);
    apbRead(4'd3, rdVal, rdErr);
    checkOutput("irqclr_rd", {rdErr, rdVal}, 9'h000);

    // Held read pops exactly once
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'd0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    checkOutput("held_rd_data", prdata, 8'hA1);
    repeat (20) @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("held_status", rdVal, 8'h05);
    apbRead(4'd0, rdVal, rdErr);
    checkOutput("held_next", rdVal, 8'hA2);

    // Fill TX while tx_done stays low
    for (int i = 0; i < 4; i++) begin
      apbWrite(4'd0, 8'h10 + 8'(i), rdErr);
      checkOutput("tx_fill_err", rdErr, 1'b0);
    end
    apbWrite(4'd0, 8'h99, rdErr);
    checkOutput("tx_full_err", rdErr, 1'b1);
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("tx_full_status", rdVal, 8'h28);
    checkOutput("tx_full_head", tx_data, 8'h10);

    // RX interrupt follows FIFO occupancy
    apbWrite(4'd2, 8'h05, rdErr);
    applyStimulus(8'h77);
    @(negedge pclk);
    checkOutput("rx_irq_on", rx_interrupt, 1'b1);
    apbRead(4'd0, rdVal, rdErr);
    checkOutput("rx_irq_data", rdVal, 8'h77);
    @(negedge pclk);
    checkOutput("rx_irq_off", rx_interrupt, 1'b0);

    // Asynchronous reset mid-transmit
    checkOutput("pre_rst_transmit", transmit, 1'b1);
    @(negedge pclk);
    #2;
    npreset = 1'b0;
    #1;
    checkOutput("async_rst_transmit", transmit, 1'b0);
    checkOutput("async_rst_tx_data", tx_data, 8'h00);
    @(negedge pclk);
    npreset = 1'b1;
    repeat (2) @(negedge pclk);
    apbRead(4'd1, rdVal, rdErr);
    checkOutput("post_rst_status", rdVal, 8'h04);
    apbRead(4'd2, rdVal, rdErr);
    checkOutput("post_rst_ctrl", rdVal, 8'h04);
    checkOutput("post_rst_transmit", transmit, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_kmi_fifo_slave.md
Name: apb_kmi_fifo_slave

Overview:
Parametrised APB slave bridging the processor bus to the KMI receive and transmit blocks. Incoming RX bytes and outgoing TX bytes are buffered in independent FIFOs. A small register map provides data, status, control and interrupt-clear access. The block runs on a single clock domain and replaces the unbuffered single-byte KMI slave.

Parameters:
DATA_W, 8, data path width for rx_data, tx_data, pwdata and prdata; must be at least 8.
RX_DEPTH, 4, RX FIFO entries; power of 2, at least 2.
TX_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
ADDR_W, 4, paddr width; only paddr[1:0] is decoded and the upper bits must be 0.

Ports:
pclk  in  1  APB clock; every flop is clocked on its rising edge.
npreset  in  1  Asynchronous active-low reset.
psel  in  1  APB select.
penable  in  1  APB enable.
pwrite  in  1  APB write when 1, read when 0.
paddr  in  ADDR_W  Register address.
pwdata  in  DATA_W  Write data.
prdata  out  DATA_W  Read data.
pready  out  1  Ready.
pslverr  out  1  Transfer error.
rx_data  in  DATA_W  Byte from the receive block.
receive  in  1  Receive request, 4-phase.
rx_done  out  1  Receive acknowledge, 4-phase.
tx_data  out  DATA_W  Byte to the transmit block.
transmit  out  1  Transmit request.
tx_done  in  1  Transmit complete, 4-phase.
rx_interrupt  out  1  RX interrupt.
tx_interrupt  out  1  TX interrupt.

Behaviour:
- Reset (npreset=0, asynchronous): both FIFOs empty, both FSMs idle, overflow=0, CONTROL=0x4. Outputs: prdata=0, pslverr=0, rx_done=0, transmit=0, tx_data=0, both interrupts 0. Reset mid-handshake abandons it; buffered data is lost.
- Access cycle: psel=1 and penable=1. pready=1 on every access cycle (zero wait states).
- Register side effects (pop, push, write) happen exactly once per transfer, on the first access cycle. An internal "done" flag is set on that cycle and is cleared when psel=0.
- prdata and pslverr are combinational during read access cycles and are 0 otherwise. pslverr is also asserted on write access cycles where the address or write is illegal (see map).
- Register map (paddr[1:0]):
  - 0 DATA, read: pops the RX head. If the RX FIFO is empty, prdata=0, pslverr=1 and there is no pop.
  - 0 DATA, write: pushes pwdata to the TX FIFO. If the TX FIFO is full, pslverr=1 and the data is dropped.
  - 1 STATUS, read-only: bit0 rx_not_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_overflow (sticky), bit5 tx_busy; upper bits 0. A write sets pslverr=1 and is ignored.
  - 2 CONTROL, read/write: bit0 rx_irq_en, bit1 tx_irq_en, bit2 enable; upper bits read 0.
  - 3 IRQ_CLR, write-only: writing 1 to bit4 clears rx_overflow. Reads return 0 with pslverr=0.
  - Any paddr with upper bits nonzero: read returns 0 with pslverr=1; write sets pslverr=1 and is ignored.
- RX FSM, states RX_IDLE and RX_ACK:
  - RX_IDLE: when receive=1 and enable=1, push rx_data and go to RX_ACK. If the RX FIFO is full, drop the byte, set rx_overflow and still go to RX_ACK.
  - RX_ACK: rx_done=1 (registered). Stay until receive=0, then go to RX_IDLE with rx_done=0.
  - Latency: rx_done rises 1 cycle after receive is sampled high.
- TX FSM, states TX_IDLE, TX_BUSY and TX_WAIT:
  - TX_IDLE: when enable=1 and the TX FIFO is not empty, register tx_data=head, set transmit=1 and go to TX_BUSY.
  - TX_BUSY: hold tx_data and transmit stable. When tx_done=1, pop the head, set transmit=0 and go to TX_WAIT.
  - TX_WAIT: when tx_done=0, go to TX_IDLE.
  - tx_busy = (state != TX_IDLE).
- Simultaneous events:
  - RX push and pop in the same cycle on a full FIFO: the push is accepted and the count is unchanged.
  - Pop on an empty FIFO uses pre-cycle state: it errors and the same-cycle push lands.
  - TX push and pop in the same cycle are both honoured.
  - rx_overflow set and IRQ_CLR in the same cycle: set wins.
- Clearing enable=0 does not abort an in-progress handshake; it only blocks new starts.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = MSBs differ and the other bits are equal.
- Interrupts (registered):
  - rx_interrupt = rx_irq_en & (rx_not_empty | rx_overflow).
  - tx_interrupt = tx_irq_en & tx_empty & !tx_busy.

Test Plan:
- Reset, then read STATUS: prdata=0x04; CONTROL reads 0x04; all handshake outputs 0.
- rx_data=0x6C with receive=1: rx_done=1 one cycle later; drop receive and rx_done falls. DATA read returns 0x6C with pslverr=0. A second DATA read returns 0 with pslverr=1.
- Write 0x6C then 0x05 to DATA: transmit=1 with tx_data=0x6C. Pulse tx_done in 4-phase and tx_data becomes 0x05. After the second handshake STATUS bit2=1 and bit5=0.
- Push 5 RX bytes 0x01-0x05 with RX_DEPTH=4: STATUS bit1=1, bit4=1. Reads return 0x01-0x04. IRQ_CLR 0x10 clears bit4.
- psel and penable held for 20 cycles on a DATA read: exactly one pop occurs. Fill TX with 4 writes while tx_done=0; the 5th write gets pslverr=1.
- CONTROL=0x05 with 1 byte in RX: rx_interrupt=1, then 0 after it is read. Assert npreset mid TX_BUSY: transmit=0 immediately and the FIFOs are empty.
